rob_reader: RTL and testbench
=============================

# rob_reader

In-order drain and tag-allocation controller for the 16-entry reorder buffer memory, the read side of that buffer. It issues sequence tags (write addresses) to outgoing requests and retires returning data strictly in tag order. It polls the memory's valid flag at the head pointer, pulses the memory read strobe to free the slot, and presents the data on a valid/ready output stage. It sits between the reorder memory and the downstream in-order consumer.

## Interface
- DATA_W, 8, data width; matches the memory entry width.
- DEPTH, 16, number of entries; must be a power of two.
- AW, 4, address/tag width, log2(DEPTH).
- TIMEOUT_CYC, 255, head-stall limit; used only with ROB_READER_TIMEOUT_EN.

- clk  in  1  single clock; all state on its rising edge.
- rst  in  1  asynchronous, active-high reset.
- alloc_req_i  in  1  requester asks for a new tag.
- alloc_gnt_o  out  1  tag granted this cycle (combinational).
- alloc_tag_o  out  AW  tag granted; valid when alloc_gnt_o=1.
- mem_raddr_o  out  AW  head read address to the memory.
- mem_re_o  out  1  read/clear strobe to the memory.
- mem_we_i  in  1  copy of the memory's write strobe.
- mem_valid_i  in  1  memory valid flag at mem_raddr_o.
- mem_data_i  in  DATA_W  memory data at mem_raddr_o.
- out_valid_o  out  1  output data valid.
- out_data_o  out  DATA_W  retired data, in tag order.
- out_ready_i  in  1  consumer accepts this cycle.
- occupancy_o  out  AW+1  tags issued and not yet read from memory.
- err_timeout_o  out  1  sticky head-stall error.

## Operation
- State: issue pointer wp (AW bits), head pointer rp (AW bits), count (AW+1 bits), output register {out_valid_o, out_data_o}.
- Allocation: alloc_gnt_o = alloc_req_i && (count < DEPTH). alloc_tag_o = wp. On grant, wp <= wp+1, wrapping mod DEPTH.
- Drain: mem_raddr_o = rp. mem_re_o = mem_valid_i && (count != 0) && !mem_we_i && (!out_valid_o || out_ready_i).
- On mem_re_o: out_data_o <= mem_data_i, out_valid_o <= 1, rp <= rp+1 (wrapping).
- Else if out_ready_i: out_valid_o <= 0.
- count_next = count + alloc_gnt_o - mem_re_o. occupancy_o = count.
- mem_re_o is suppressed whenever mem_we_i=1. The memory gives write priority and silently drops a same-cycle clear, so the read is retried on the next cycle.
- Full (count==DEPTH): no grant. The decision uses registered count, so a same-cycle retire does not enable a grant.
- Empty (count==0): mem_re_o=0 regardless of mem_valid_i.
- Simultaneous grant and retire: count unchanged, both pointers advance.
- Out-of-order arrivals at non-head tags are ignored until rp reaches them.

## Timing
- Reset values: alloc_gnt_o follows alloc_req_i (count=0, so it is granted). alloc_tag_o=0, mem_raddr_o=0, mem_re_o=0, out_valid_o=0, out_data_o=0, occupancy_o=0, err_timeout_o=0.
- Reset is asynchronous mid-operation: all pointers, count and output state clear immediately. Outstanding tags are abandoned. The memory must share the same rst.
- Head data written at edge N becomes memory-valid after edge N. mem_re_o is high in cycle N (before edge N+1), and out_valid_o is high after edge N+1. Latency is 1 cycle from memory-valid to output.
- Sustained throughput is one entry per cycle while out_ready_i=1 and no write collides.
- Output holds data stable while out_valid_o=1 and out_ready_i=0.

## Configuration
- ROB_READER_TIMEOUT_EN defined: a stall counter increments each cycle that count!=0 and mem_re_o=0, and clears on mem_re_o.
  - When the counter reaches TIMEOUT_CYC, err_timeout_o is set and stays set until rst.
  - The counter saturates.
- Undefined: no counter is built and err_timeout_o is tied to 0.

## Test plan
- Reset, then 16 back-to-back alloc_req_i -> tags 0..15 granted; 17th request denied; occupancy_o=16.
- Write tags in order 3,1,0,2 with out_ready_i=1 -> out_data_o sequence follows tag order 0,1,2,3. Retire of tag 0 occurs 1 cycle after its write is visible.
- Head valid with mem_we_i=1 on the same cycle -> mem_re_o=0 that cycle and 1 on the next cycle; no entry lost or duplicated.
- out_ready_i held 0 for 5 cycles with 2 entries valid -> exactly one entry is latched and held stable; mem_re_o=0 until ready. Then both entries drain in order.
- Fill and drain 40 entries through wrap -> tags wrap 15->0, output order is preserved, and occupancy_o ends at 0.
- With ROB_READER_TIMEOUT_EN and TIMEOUT_CYC=8: allocate 1 tag and never write it -> err_timeout_o=1 after 8 cycles and stays 1 until rst. Asserting rst mid-stream clears all outputs immediately.

Source files
------------

// File: rtl/rob_reader.sv
// Purpose : in-order tag issue and drain controller for the read side of a reorder memory.
// Latency : 1 cycle from head entry becoming memory-valid to out_valid_o.
// Backpressure: out_ready_i=0 holds the output register; the next head read waits until it frees.
//
// Ports:
//   clk, rst                 single clock, asynchronous active-high reset
//   alloc_req_i/gnt_o/tag_o  tag allocation; grant is combinational, tag is the issue pointer
//   mem_raddr_o, mem_re_o    head address and read/clear strobe to the memory
//   mem_we_i                 memory write strobe copy; a write blocks the clear this cycle
//   mem_valid_i, mem_data_i  memory valid flag and data at the head address
//   out_valid_o/data_o/ready_i  registered valid/ready output stage, tag order
//   occupancy_o              tags issued and not yet read from memory
//   err_timeout_o            sticky head-stall error
// Optional feature: define ROB_READER_TIMEOUT_EN to build the head-stall watchdog.
module rob_reader #(
    parameter int DATA_W      = 8,
    parameter int DEPTH       = 16,
    parameter int AW          = 4,
    parameter int TIMEOUT_CYC = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              alloc_req_i,
    output logic              alloc_gnt_o,
    output logic [AW-1:0]     alloc_tag_o,
    output logic [AW-1:0]     mem_raddr_o,
    output logic              mem_re_o,
    input  logic              mem_we_i,
    input  logic              mem_valid_i,
    input  logic [DATA_W-1:0] mem_data_i,
    output logic              out_valid_o,
    output logic [DATA_W-1:0] out_data_o,
    input  logic              out_ready_i,
    output logic [AW:0]       occupancy_o,
    output logic              err_timeout_o
);

    localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

    generate
        if (DEPTH != (1 << AW) || TIMEOUT_CYC < 1) begin : g_bad_cfg
            $error("rob_reader: DEPTH must equal 2**AW and TIMEOUT_CYC must be positive");
        end
    endgenerate

    logic [AW-1:0] wp;
    logic [AW-1:0] rp;
    logic [AW:0]   count;

    // Full check uses the registered count: a retire in the same cycle
    // does not open a slot for a grant until the next cycle.
    assign alloc_gnt_o = alloc_req_i && (count < DEPTH_C);
    assign alloc_tag_o = wp;
    assign mem_raddr_o = rp;
    assign occupancy_o = count;

    // The memory gives its write port priority and drops a same-cycle clear,
    // so the read is held off while a write is in flight and retried next cycle.
    assign mem_re_o = mem_valid_i && (count != '0) && !mem_we_i &&
                      (!out_valid_o || out_ready_i);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wp          <= '0;
            rp          <= '0;
            count       <= '0;
            out_valid_o <= 1'b0;
            out_data_o  <= '0;
        end else begin
            if (alloc_gnt_o) begin
                wp <= wp + 1'b1;
            end

            case ({alloc_gnt_o, mem_re_o})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase

            if (mem_re_o) begin
                out_data_o  <= mem_data_i;
                out_valid_o <= 1'b1;
                rp          <= rp + 1'b1;
            end else if (out_ready_i) begin
                out_valid_o <= 1'b0;
            end
        end
    end

`ifdef ROB_READER_TIMEOUT_EN
    localparam int          TW   = (TIMEOUT_CYC < 2) ? 1 : $clog2(TIMEOUT_CYC + 1);
    localparam logic [TW-1:0] TLIM = TW'(TIMEOUT_CYC);

    logic [TW-1:0] stall_cnt;
    logic [TW-1:0] stall_nxt;
    logic          err_q;

    // Counts cycles where tags are outstanding but the head is not retired;
    // any retire restarts the count, and it parks at the limit.
    always_comb begin
        stall_nxt = stall_cnt;
        if (mem_re_o) begin
            stall_nxt = '0;
        end else if ((count != '0) && (stall_cnt != TLIM)) begin
            stall_nxt = stall_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt <= '0;
            err_q     <= 1'b0;
        end else begin
            stall_cnt <= stall_nxt;
            if (stall_nxt == TLIM) begin
                err_q <= 1'b1;
            end
        end
    end

    assign err_timeout_o = err_q;
`else
    assign err_timeout_o = 1'b0;
`endif

endmodule

// File: tb/tb_rob_reader.sv
module tb_rob_reader;

    localparam int DATA_W = 8;
    localparam int DEPTH  = 16;
    localparam int AW     = 4;
    localparam int TO_CYC = 8;
`ifdef ROB_READER_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst;
    logic              alloc_req;
    logic              alloc_gnt;
    logic [AW-1:0]     alloc_tag;
    logic [AW-1:0]     mem_raddr;
    logic              mem_re;
    logic              mem_we;
    logic              mem_valid;
    logic [DATA_W-1:0] mem_data;
    logic              out_valid;
    logic [DATA_W-1:0] out_data;
    logic              out_ready;
    logic [AW:0]       occupancy;
    logic              err_timeout;

    logic [AW-1:0]     waddr;
    logic [DATA_W-1:0] wdata;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    rob_reader #(.DATA_W(DATA_W), .DEPTH(DEPTH), .AW(AW), .TIMEOUT_CYC(TO_CYC)) dut (
        .clk          (clk),
        .rst          (rst),
        .alloc_req_i  (alloc_req),
        .alloc_gnt_o  (alloc_gnt),
        .alloc_tag_o  (alloc_tag),
        .mem_raddr_o  (mem_raddr),
        .mem_re_o     (mem_re),
        .mem_we_i     (mem_we),
        .mem_valid_i  (mem_valid),
        .mem_data_i   (mem_data),
        .out_valid_o  (out_valid),
        .out_data_o   (out_data),
        .out_ready_i  (out_ready),
        .occupancy_o  (occupancy),
        .err_timeout_o(err_timeout)
    );

    // Reorder memory environment: write has priority and drops a same-cycle clear.
    logic              mem_v [DEPTH];
    logic [DATA_W-1:0] mem_d [DEPTH];

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_v[i] <= 1'b0;
                mem_d[i] <= '0;
            end
        end else if (mem_we) begin
            mem_v[waddr] <= 1'b1;
            mem_d[waddr] <= wdata;
        end else if (mem_re) begin
            mem_v[mem_raddr] <= 1'b0;
        end
    end

    assign mem_valid = mem_v[mem_raddr];
    assign mem_data  = mem_d[mem_raddr];

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic rst_pulse();
        rst       = 1'b1;
        alloc_req = 1'b0;
        mem_we    = 1'b0;
        waddr     = '0;
        wdata     = '0;
        out_ready = 1'b0;
        nxt();
        rst = 1'b0;
    endtask

    task automatic do_alloc(input int n, input int base);
        for (int k = 0; k < n; k++) begin
            alloc_req = 1'b1;
            @(negedge clk);
            n_checks++;
            if ({alloc_gnt, alloc_tag} !== {1'b1, AW'((base + k) % DEPTH)}) begin
                n_fail++;
                $display("FAIL alloc_tag k=%0d: got gnt=%0b tag=%0d expected gnt=1 tag=%0d",
                         k, alloc_gnt, alloc_tag, (base + k) % DEPTH);
            end
            nxt();
        end
        alloc_req = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; alloc_req = 1'b1; mem_we = 1'b0; out_ready = 1'b0;
        waddr = '0; wdata = '0;
        #2;
        n_checks++;
        if (alloc_gnt !== 1'b1) begin
            n_fail++; $display("FAIL reset_gnt_follows_req: got %0b expected 1", alloc_gnt);
        end
        n_checks++;
        if ({alloc_tag, mem_raddr, mem_re, out_valid, out_data, occupancy, err_timeout} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: got tag=%0d ra=%0d re=%0b ov=%0b od=%0h occ=%0d err=%0b expected all 0",
                     alloc_tag, mem_raddr, mem_re, out_valid, out_data, occupancy, err_timeout);
        end
        alloc_req = 1'b0;
        #1;
        n_checks++;
        if (alloc_gnt !== 1'b0) begin
            n_fail++; $display("FAIL reset_gnt_no_req: got %0b expected 0", alloc_gnt);
        end
        nxt();
        rst = 1'b0;
    endtask

    task automatic test_fill();
        rst_pulse();
        do_alloc(16, 0);
        alloc_req = 1'b1;
        @(negedge clk);
        n_checks++;
        if ({alloc_gnt, occupancy} !== {1'b0, 5'd16}) begin
            n_fail++;
            $display("FAIL full_deny: got gnt=%0b occ=%0d expected gnt=0 occ=16", alloc_gnt, occupancy);
        end
        nxt();
        alloc_req = 1'b0;
        @(negedge clk);
        n_checks++;
        if (occupancy !== 5'd16) begin
            n_fail++; $display("FAIL full_hold: got occ=%0d expected 16", occupancy);
        end
        nxt();
    endtask

    // Writes tags 3,1,0,2; tag 2's write collides with the head read of tag 1.
    task automatic test_order();
        int          we_t [10] = '{1, 1, 1, 0, 1, 0, 0, 0, 0, 0};
        int          wa_t [10] = '{3, 1, 0, 0, 2, 0, 0, 0, 0, 0};
        logic [7:0]  wd_t [10] = '{8'h33, 8'h11, 8'hA0, 8'h00, 8'h22, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        logic        re_t [10] = '{0, 0, 0, 1, 0, 1, 1, 1, 0, 0};
        int          ra_t [10] = '{0, 0, 0, 0, 0, 1, 2, 3, 0, 0};
        logic        ov_t [10] = '{0, 0, 0, 0, 1, 0, 1, 1, 1, 0};
        logic [7:0]  od_t [10] = '{8'h00, 8'h00, 8'h00, 8'h00, 8'hA0, 8'h00, 8'h11, 8'h22, 8'h33, 8'h00};
        int          oc_t [10] = '{4, 4, 4, 4, 3, 3, 2, 1, 0, 0};
        rst_pulse();
        do_alloc(4, 0);
        out_ready = 1'b1;
        for (int c = 0; c < 10; c++) begin
            mem_we = 1'(we_t[c]);
            waddr  = AW'(wa_t[c]);
            wdata  = wd_t[c];
            @(negedge clk);
            n_checks++;
            if ({mem_re, out_valid, occupancy} !== {re_t[c], ov_t[c], 5'(oc_t[c])}) begin
                n_fail++;
                $display("FAIL order_ctl c=%0d: got re=%0b ov=%0b occ=%0d expected re=%0b ov=%0b occ=%0d",
                         c, mem_re, out_valid, occupancy, re_t[c], ov_t[c], oc_t[c]);
            end
            if (re_t[c]) begin
                n_checks++;
                if (mem_raddr !== AW'(ra_t[c])) begin
                    n_fail++;
                    $display("FAIL order_raddr c=%0d: got %0d expected %0d", c, mem_raddr, ra_t[c]);
                end
            end
            if (ov_t[c]) begin
                n_checks++;
                if (out_data !== od_t[c]) begin
                    n_fail++;
                    $display("FAIL order_data c=%0d: got %0h expected %0h", c, out_data, od_t[c]);
                end
            end
            nxt();
        end
        mem_we = 1'b0;
    endtask

    // Two entries valid while the consumer stalls: only one is latched and held.
    task automatic test_backpressure();
        logic        rd_t [10] = '{0, 0, 0, 0, 0, 0, 0, 1, 1, 1};
        logic        we_t [10] = '{1, 1, 0, 0, 0, 0, 0, 0, 0, 0};
        logic        re_t [10] = '{0, 0, 1, 0, 0, 0, 0, 1, 0, 0};
        int          ra_t [10] = '{0, 0, 0, 0, 0, 0, 0, 1, 0, 0};
        logic        ov_t [10] = '{0, 0, 0, 1, 1, 1, 1, 1, 1, 0};
        logic [7:0]  od_t [10] = '{8'h00, 8'h00, 8'h00, 8'h5C, 8'h5C, 8'h5C, 8'h5C, 8'h5C, 8'hC5, 8'h00};
        int          oc_t [10] = '{2, 2, 2, 1, 1, 1, 1, 1, 0, 0};
        rst_pulse();
        do_alloc(2, 0);
        for (int c = 0; c < 10; c++) begin
            out_ready = rd_t[c];
            mem_we    = we_t[c];
            waddr     = (c == 1) ? AW'(1) : AW'(0);
            wdata     = (c == 1) ? 8'hC5 : 8'h5C;
            @(negedge clk);
            n_checks++;
            if ({mem_re, out_valid, occupancy} !== {re_t[c], ov_t[c], 5'(oc_t[c])}) begin
                n_fail++;
                $display("FAIL bp_ctl c=%0d: got re=%0b ov=%0b occ=%0d expected re=%0b ov=%0b occ=%0d",
                         c, mem_re, out_valid, occupancy, re_t[c], ov_t[c], oc_t[c]);
            end
            if (re_t[c]) begin
                n_checks++;
                if (mem_raddr !== AW'(ra_t[c])) begin
                    n_fail++;
                    $display("FAIL bp_raddr c=%0d: got %0d expected %0d", c, mem_raddr, ra_t[c]);
                end
            end
            if (ov_t[c]) begin
                n_checks++;
                if (out_data !== od_t[c]) begin
                    n_fail++;
                    $display("FAIL bp_data c=%0d: got %0h expected %0h", c, out_data, od_t[c]);
                end
            end
            nxt();
        end
        mem_we = 1'b0;
    endtask

    // 40 entries in four batches of 10; tags wrap 15->0 inside the second batch.
    task automatic test_wrap();
        int rx = 0;
        rst_pulse();
        out_ready = 1'b1;
        for (int b = 0; b < 4; b++) begin
            do_alloc(10, b * 10);
            for (int k = 0; k < 10; k++) begin
                mem_we = 1'b1;
                waddr  = AW'((b * 10 + k) % DEPTH);
                wdata  = 8'((b * 10 + k) * 7 + 3);
                nxt();
            end
            mem_we = 1'b0;
            for (int c = 0; c < 14; c++) begin
                @(negedge clk);
                if (out_valid === 1'b1 && rx < 40) begin
                    n_checks++;
                    if (out_data !== 8'(rx * 7 + 3)) begin
                        n_fail++;
                        $display("FAIL wrap_data idx=%0d: got %0h expected %0h", rx, out_data, 8'(rx * 7 + 3));
                    end
                    rx++;
                end
                nxt();
            end
        end
        n_checks++;
        if (rx !== 40) begin
            n_fail++; $display("FAIL wrap_count: got %0d entries expected 40", rx);
        end
        @(negedge clk);
        n_checks++;
        if ({occupancy, alloc_tag, mem_raddr} !== {5'd0, AW'(40 % DEPTH), AW'(40 % DEPTH)}) begin
            n_fail++;
            $display("FAIL wrap_end: got occ=%0d tag=%0d ra=%0d expected occ=0 tag=8 ra=8",
                     occupancy, alloc_tag, mem_raddr);
        end
        nxt();
    endtask

    task automatic test_timeout();
        logic exp_err;
        rst_pulse();
        do_alloc(1, 0);
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            exp_err = TO_EN && (i >= TO_CYC);
            n_checks++;
            if (err_timeout !== exp_err) begin
                n_fail++;
                $display("FAIL timeout_err stall=%0d: got %0b expected %0b", i, err_timeout, exp_err);
            end
            nxt();
        end
        // Retiring the stuck head must not clear the sticky error.
        out_ready = 1'b1;
        mem_we = 1'b1; waddr = '0; wdata = 8'h42;
        nxt();
        mem_we = 1'b0;
        nxt();
        nxt();
        @(negedge clk);
        n_checks++;
        if ({err_timeout, occupancy} !== {TO_EN, 5'd0}) begin
            n_fail++;
            $display("FAIL timeout_sticky: got err=%0b occ=%0d expected err=%0b occ=0",
                     err_timeout, occupancy, TO_EN);
        end
        rst = 1'b1;
        #1;
        n_checks++;
        if (err_timeout !== 1'b0) begin
            n_fail++; $display("FAIL timeout_rst_clear: got %0b expected 0", err_timeout);
        end
        nxt();
        rst = 1'b0;
    endtask

    task automatic test_async_reset();
        rst_pulse();
        do_alloc(3, 0);
        out_ready = 1'b0;
        mem_we = 1'b1; waddr = '0; wdata = 8'h77;
        nxt();
        mem_we = 1'b0;
        nxt();
        @(negedge clk);
        n_checks++;
        if ({out_valid, out_data, occupancy, alloc_tag} !== {1'b1, 8'h77, 5'd2, AW'(3)}) begin
            n_fail++;
            $display("FAIL arst_pre: got ov=%0b od=%0h occ=%0d tag=%0d expected ov=1 od=77 occ=2 tag=3",
                     out_valid, out_data, occupancy, alloc_tag);
        end
        rst = 1'b1;
        #1;
        n_checks++;
        if ({alloc_gnt, alloc_tag, mem_raddr, mem_re, out_valid, out_data, occupancy, err_timeout} !== '0) begin
            n_fail++;
            $display("FAIL arst_clear: got gnt=%0b tag=%0d ra=%0d re=%0b ov=%0b od=%0h occ=%0d err=%0b expected all 0",
                     alloc_gnt, alloc_tag, mem_raddr, mem_re, out_valid, out_data, occupancy, err_timeout);
        end
        nxt();
        rst = 1'b0;
    endtask

    initial begin
        test_reset();
        test_fill();
        test_order();
        test_backpressure();
        test_wrap();
        test_timeout();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1);
    end

endmodule
